dma_path_controller: RTL
========================

Name: dma_path_controller

Overview:
- Sits directly downstream of the per-core DMA controller and grants its `dma_req`.
- Captures the 128-bit command beat from the write stream, decodes it, and forwards the header and any write payload to the host-side TX stream.
- For read commands, it streams host RX completion beats back to the DMA controller.
- Single channel; one transfer in flight at a time.

Parameters:
- `MAX_LEN`, 16'd4096: largest legal transfer length in 128-bit beats; larger lengths are rejected.
- `TIMEOUT_CYCLES`, 16'd1024: idle-cycle limit in RD_DATA; used only with the optional feature.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `dma_req`, in, 1: transfer request from the DMA controller.
- `dma_resp`, out, 1: grant; one-cycle pulse.
- `dma_write_valid`, in, 1: command/payload beat valid.
- `dma_write_data`, in, 128: command/payload beat.
- `dma_write_ready`, out, 1: block accepts a write-stream beat.
- `dma_read_valid`, out, 1: read data beat valid.
- `dma_read_data`, out, 128: read data beat.
- `dma_read_ready`, in, 1: DMA controller accepts a read beat.
- `host_tx_valid`, out, 1: host TX beat valid.
- `host_tx_data`, out, 128: host TX beat (header or payload).
- `host_tx_last`, out, 1: final beat of a TX packet.
- `host_tx_ready`, in, 1: host accepts a TX beat.
- `host_rx_valid`, in, 1: host read completion beat valid.
- `host_rx_data`, in, 128: host read completion beat.
- `host_rx_ready`, out, 1: block accepts an RX beat.
- `busy`, out, 1: high in every state except IDLE.
- `err`, out, 1: one-cycle pulse on a rejected command or timeout.

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - All outputs are 0, the state is IDLE and the counters are cleared.
  - Reset mid-transfer aborts immediately; no beats are emitted afterwards.
- Command word fields:
  - [13:0] local_addr
  - [53:14] host_addr
  - [69:54] length in beats
  - [77:70] opcode: 8'h03 = write, 8'h01 = read
  - [127:78] must be 0; this is not checked.
- Transfer rule: a beat transfers on any interface when valid && ready are both high on the same rising edge.
- IDLE:
  - `dma_req` high -> `dma_resp` = 1 for exactly one cycle, then go to CMD.
  - `dma_req` sampled in other states is ignored.
- CMD:
  - `dma_write_ready` = 1.
  - On the first write-stream beat, latch the word into `hdr`, `len` and `opc`, then set `dma_write_ready` = 0 next cycle.
  - opc == 03 and len <= MAX_LEN -> WR_HDR.
  - opc == 01 and len <= MAX_LEN -> RD_HDR.
  - Otherwise -> ERR.
- WR_HDR:
  - `host_tx_valid` = 1 and `host_tx_data` = `hdr`.
  - `host_tx_last` = 1 iff len == 0.
  - On transfer: len == 0 -> DONE, else -> WR_DATA.
- WR_DATA, zero-bubble pass-through:
  - `host_tx_valid` = `dma_write_valid`, `host_tx_data` = `dma_write_data`, `dma_write_ready` = `host_tx_ready`.
  - `cnt` increments on each transfer.
  - `host_tx_last` = 1 when cnt == len-1.
  - The transfer at cnt == len-1 goes to DONE; write beats beyond len are not accepted.
- RD_HDR:
  - Same as WR_HDR except `host_tx_last` = 1 always.
  - On transfer: len == 0 -> DONE, else -> RD_DATA.
- RD_DATA, pass-through:
  - `dma_read_valid` = `host_rx_valid`, `dma_read_data` = `host_rx_data`, `host_rx_ready` = `dma_read_ready`.
  - Count transfers; after len beats go to DONE.
  - `host_rx_ready` = 0 in every other state, so extra RX beats stall.
- ERR: `err` = 1 for one cycle -> IDLE. No host traffic is generated.
- DONE: one cycle -> IDLE. `cnt` is cleared.
- Minimum latency from `dma_req` to the header beat on host TX is 3 cycles (grant, command, header).
- `cnt` and `len` are 16-bit. cnt == len-1 is evaluated only when len != 0, so no wrap occurs.
- Simultaneous RX beat and DONE transition: the beat counted at len is the last one accepted.

Optional Feature:
- Macro: `DMA_PATH_TIMEOUT_EN`.
- Defined:
  - A 16-bit idle counter runs in RD_DATA. It resets on every RX transfer and increments otherwise.
  - Reaching `TIMEOUT_CYCLES` -> ERR, which pulses `err` and returns to IDLE, discarding the remaining beats.
- Undefined: no counter exists, and RD_DATA waits indefinitely.

Test Plan:
1. Reset with `reset_n` = 0, held mid-WR_DATA -> all outputs 0 and state IDLE within the same cycle; `busy` = 0.
2. `dma_req`, then command opc 03, len 3, host_addr 40'h12_3456_7890, local_addr 14'h0010, payload A/B/C:
   - host TX carries hdr, A, B, C.
   - `host_tx_last` is set only on C.
   - `dma_resp` pulses exactly once.
3. Write len 2 with `host_tx_ready` toggled 1,0,1,0 -> no beat lost or duplicated; `dma_write_ready` mirrors `host_tx_ready`.
4. Read opc 01, len 4:
   - The header is sent with last = 1.
   - Four RX beats 0x11..0x44 appear on `dma_read_data` in order.
   - A 5th RX beat is not accepted (`host_rx_ready` = 0).
5. Command opc 8'h07, or opc 03 with len 4097 -> `err` pulses once, no host TX beat, back to IDLE.
6. With `DMA_PATH_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: read len 2 with only one RX beat supplied -> `err` pulses 8 cycles after the last beat, then IDLE.

Source files
------------

// File: rtl/dma_path_controller.sv
// -----------------------------------------------------------------------------
// dma_path_controller
//   Single-channel bridge between a per-core DMA controller and the host-side
//   TX/RX streams. It grants a DMA request and captures one 128-bit command
//   beat. It then forwards the command header, plus any write payload, to host
//   TX. For reads it passes host RX completion beats back to the DMA read
//   stream. Only one transfer is in flight at a time.
//
//   Command word: [13:0] local_addr, [53:14] host_addr, [69:54] length (beats),
//                 [77:70] opcode (8'h03 write, 8'h01 read).
//
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     dma_req / dma_resp                request in, one-cycle grant pulse out
//     dma_write_valid/data/ready        command + write payload stream (in)
//     dma_read_valid/data/ready         read data stream (out)
//     host_tx_valid/data/last/ready     header + payload to host
//     host_rx_valid/data/ready          read completions from host
//     busy                              high whenever not IDLE
//     err                               one-cycle pulse on reject / timeout
//
//   Optional feature macro: DMA_PATH_TIMEOUT_EN
//     When defined, RD_DATA aborts to ERR after TIMEOUT_CYCLES consecutive
//     cycles without an RX transfer. When undefined, RD_DATA waits forever.
// -----------------------------------------------------------------------------
module dma_path_controller #(
    parameter logic [15:0] MAX_LEN        = 16'd4096,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         dma_req,
    output logic         dma_resp,
    input  logic         dma_write_valid,
    input  logic [127:0] dma_write_data,
    output logic         dma_write_ready,
    output logic         dma_read_valid,
    output logic [127:0] dma_read_data,
    input  logic         dma_read_ready,
    output logic         host_tx_valid,
    output logic [127:0] host_tx_data,
    output logic         host_tx_last,
    input  logic         host_tx_ready,
    input  logic         host_rx_valid,
    input  logic [127:0] host_rx_data,
    output logic         host_rx_ready,
    output logic         busy,
    output logic         err
);

    localparam logic [7:0] OP_WR = 8'h03;
    localparam logic [7:0] OP_RD = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WR_HDR, S_WR_DATA, S_RD_HDR, S_RD_DATA, S_ERR, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [127:0]  hdr;      // latched command word; opcode lives in hdr[77:70]
    logic [15:0]   len;
    logic [15:0]   cnt;
    logic          resp_q;

    logic [15:0]   cmd_len;
    logic [7:0]    cmd_opc;
    logic          cnt_last;
    logic          rx_xfer;
    logic          data_xfer;

    assign cmd_len  = dma_write_data[69:54];
    assign cmd_opc  = dma_write_data[77:70];
    // Guarding on len != 0 keeps len-1 from wrapping to 16'hFFFF.
    assign cnt_last = (len != 16'd0) && (cnt == len - 16'd1);
    assign rx_xfer  = host_rx_valid && host_rx_ready;
    // Beat accepted in either data phase (write pass-through or read pass-through).
    assign data_xfer = ((state == S_WR_DATA) && dma_write_valid && host_tx_ready) ||
                       ((state == S_RD_DATA) && rx_xfer);

`ifdef DMA_PATH_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timeout_hit;
    assign timeout_hit = (idle_cnt == TIMEOUT_CYCLES - 16'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Grant is registered so it is a clean one-cycle pulse coinciding with
    // the first CMD cycle, and is 0 while reset is held.
    assign dma_resp = resp_q;

    always_comb begin
        state_nxt       = state;
        dma_write_ready = 1'b0;
        dma_read_valid  = 1'b0;
        dma_read_data   = '0;
        host_tx_valid   = 1'b0;
        host_tx_data    = '0;
        host_tx_last    = 1'b0;
        host_rx_ready   = 1'b0;
        err             = 1'b0;
        busy            = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (dma_req) state_nxt = S_CMD;
            end
            S_CMD: begin
                dma_write_ready = 1'b1;
                if (dma_write_valid) begin
                    if (cmd_opc == OP_WR && cmd_len <= MAX_LEN)      state_nxt = S_WR_HDR;
                    else if (cmd_opc == OP_RD && cmd_len <= MAX_LEN) state_nxt = S_RD_HDR;
                    else                                             state_nxt = S_ERR;
                end
            end
            S_WR_HDR: begin
                host_tx_valid = 1'b1;
                host_tx_data  = hdr;
                host_tx_last  = (len == 16'd0);
                if (host_tx_ready) state_nxt = (len == 16'd0) ? S_DONE : S_WR_DATA;
            end
            S_WR_DATA: begin
                // Zero-bubble pass-through: the write stream sees host backpressure.
                host_tx_valid   = dma_write_valid;
                host_tx_data    = dma_write_data;
                host_tx_last    = cnt_last;
                dma_write_ready = host_tx_ready;
                if (data_xfer && cnt_last) state_nxt = S_DONE;
            end
            S_RD_HDR: begin
                host_tx_valid = 1'b1;
                host_tx_data  = hdr;
                host_tx_last  = 1'b1;
                if (host_tx_ready) state_nxt = (len == 16'd0) ? S_DONE : S_RD_DATA;
            end
            S_RD_DATA: begin
                dma_read_valid = host_rx_valid;
                dma_read_data  = host_rx_data;
                host_rx_ready  = dma_read_ready;
                if (data_xfer && cnt_last) state_nxt = S_DONE;
`ifdef DMA_PATH_TIMEOUT_EN
                else if (!rx_xfer && timeout_hit) state_nxt = S_ERR;
`endif
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            hdr    <= '0;
            len    <= '0;
            cnt    <= '0;
            resp_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            resp_q <= (state == S_IDLE) && dma_req;
            if (state == S_CMD && dma_write_valid) begin
                hdr <= dma_write_data;
                len <= cmd_len;
            end
            if (data_xfer)
                cnt <= cnt_last ? 16'd0 : cnt + 16'd1;
            else if (state == S_DONE || state == S_ERR)
                cnt <= '0;
        end
    end

`ifdef DMA_PATH_TIMEOUT_EN
    // Counts consecutive RD_DATA cycles with no RX transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (state == S_RD_DATA && !rx_xfer)
            idle_cnt <= idle_cnt + 16'd1;
        else
            idle_cnt <= '0;
    end
`endif

endmodule
